// File: rtl/fifo_param.sv
// Parametrised single-clock show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_param #(
   parameter int WIDTH    = 4,
   parameter int ADDR_W   = 2,
   parameter int AF_LEVEL = 3,
   parameter int AE_LEVEL = 1
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              flush,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              wen,
   output logic              full,
   output logic              almost_full,
   output logic [WIDTH-1:0]  rdata,
   input  logic              ren,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] C_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] C_AF  = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] C_AE  = AE_LEVEL[ADDR_W:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]  r_waddr;
   logic [ADDR_W:0]  r_raddr;
   logic             r_overflow;
   logic             r_underflow;

   logic [ADDR_W:0]  w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_wvalid;
   logic             w_rvalid;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_count  = r_waddr - r_raddr;
   assign w_empty  = (r_waddr == r_raddr);
   assign w_full   = (r_waddr[ADDR_W-1:0] == r_raddr[ADDR_W-1:0]) &&
                     (r_waddr[ADDR_W] != r_raddr[ADDR_W]);
   assign w_wvalid = wen & ~w_full;
   assign w_rvalid = ren & ~w_empty;

   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = w_count;
   assign almost_full  = (w_count >= C_AF);
   assign almost_empty = (w_count <= C_AE);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;
   assign rdata        = r_mem[r_raddr[ADDR_W-1:0]];

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_waddr     <= '0;
         r_raddr     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (flush) begin
         r_waddr     <= '0;
         r_raddr     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wvalid) r_waddr <= r_waddr + C_ONE;
         if (w_rvalid) r_raddr <= r_raddr + C_ONE;
         if (wen && w_full)   r_overflow  <= 1'b1;
         if (ren && w_empty)  r_underflow <= 1'b1;
      end
   end

   // Storage is deliberately not reset; flush suppresses the write.
   always_ff @(posedge CLK) begin
      if (w_wvalid && !flush) r_mem[r_waddr[ADDR_W-1:0]] <= wdata;
   end

endmodule
